// File: rtl/work_transmit_pkg.sv
// Shared definitions for the work-unit serial transmitter: packet sizes,
// FSM state encodings and the baud-divisor helper used by both UART ends.
package work_transmit_pkg;

    localparam int KRAMBLE_PKT_BYTES = 44;
    localparam int ICARUS_PKT_BYTES  = 64;
    localparam int ICARUS_PAD_BITS   = 160;

    // Line states of the byte framer; the packet sequencer reuses IDLE,
    // DATA (packet in flight) and DONE.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } tx_state_t;

    // Clock cycles per UART bit period (integer division, as the receiver does).
    function automatic int clks_per_bit(input int speed_mhz, input int baud);
        return (speed_mhz * 1000000) / baud;
    endfunction

endpackage

// File: rtl/work_transmit_uart_tx_byte.sv
// Single-byte 8N1 framer: start bit, 8 data bits LSB first, stop bit and an
// optional idle-high gap. busy drops in the final stop-bit cycle so the next
// byte can be loaded with no dead cycle between frames.
module uart_tx_byte
    import work_transmit_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int GAP_BITS     = 0
) (
    input  logic       clk,
    input  logic       reset_in,
    input  logic       load,
    input  logic [7:0] byte_in,
    input  logic       gap,
    output logic       TxD,
    output logic       busy
);

    localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GAP_W  = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_BITS > 0) ? (GAP_BITS - 1) : 0);
    localparam logic              GAP_EN    = (GAP_BITS > 0);

    tx_state_t         state_r;
    logic [TICK_W-1:0] tick_r;
    logic [2:0]        bit_r;
    logic [GAP_W-1:0]  gap_cnt_r;
    logic [7:0]        data_r;
    logic              txd_r;
    logic              tick_last_s;
    logic              frame_end_s;

    // Decode end of bit period and whether a new byte can be taken now.
    always_comb begin
        tick_last_s = (tick_r == TICK_LAST);
        frame_end_s = (state_r == ST_STOP) && tick_last_s;
        if (state_r == ST_IDLE) begin
            busy = 1'b0;
        end else if (frame_end_s) begin
            busy = 1'b0;
        end else begin
            busy = 1'b1;
        end
    end

    // Byte framing FSM; TxD comes straight from txd_r.
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            state_r   <= ST_IDLE;
            tick_r    <= '0;
            bit_r     <= 3'd0;
            gap_cnt_r <= '0;
            data_r    <= 8'h00;
            txd_r     <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    tick_r    <= '0;
                    bit_r     <= 3'd0;
                    gap_cnt_r <= '0;
                    if (load) begin
                        data_r  <= byte_in;
                        txd_r   <= 1'b0;
                        state_r <= ST_START;
                    end else begin
                        txd_r   <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (tick_last_s) begin
                        tick_r  <= '0;
                        bit_r   <= 3'd0;
                        txd_r   <= data_r[0];
                        state_r <= ST_DATA;
                    end else begin
                        tick_r <= tick_r + TICK_W'(1);
                    end
                end
                ST_DATA: begin
                    if (tick_last_s) begin
                        tick_r <= '0;
                        if (bit_r == 3'd7) begin
                            txd_r   <= 1'b1;
                            state_r <= ST_STOP;
                        end else begin
                            bit_r  <= bit_r + 3'd1;
                            txd_r  <= data_r[1];
                            data_r <= {1'b0, data_r[7:1]};
                        end
                    end else begin
                        tick_r <= tick_r + TICK_W'(1);
                    end
                end
                ST_STOP: begin
                    if (tick_last_s) begin
                        tick_r <= '0;
                        if (load) begin
                            data_r <= byte_in;
                            if (gap && GAP_EN) begin
                                gap_cnt_r <= '0;
                                txd_r     <= 1'b1;
                                state_r   <= ST_GAP;
                            end else begin
                                txd_r   <= 1'b0;
                                state_r <= ST_START;
                            end
                        end else begin
                            txd_r   <= 1'b1;
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        tick_r <= tick_r + TICK_W'(1);
                    end
                end
                ST_GAP: begin
                    if (tick_last_s) begin
                        tick_r <= '0;
                        if (gap_cnt_r == GAP_LAST) begin
                            txd_r   <= 1'b0;
                            state_r <= ST_START;
                        end else begin
                            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                        end
                    end else begin
                        tick_r <= tick_r + TICK_W'(1);
                    end
                end
                default: begin
                    tick_r  <= '0;
                    txd_r   <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign TxD = txd_r;

endmodule

// File: rtl/work_transmit.sv
// Work-unit transmitter: captures midstate/data2 on an accepted start and
// streams the packet image MSB byte first through the byte framer.
module work_transmit
    import work_transmit_pkg::*;
#(
    parameter int SPEED_MHZ = 50,
    parameter int BAUD      = 115200,
    parameter int ICARUS    = 0,
    parameter int GAP_BITS  = 0
) (
    input  logic         clk,
    input  logic         reset_in,
    input  logic         start,
    input  logic [255:0] midstate,
    input  logic [95:0]  data2,
    output logic         TxD,
    output logic         busy,
    output logic         done,
    output logic [6:0]   byte_index
);

    localparam int CLKS_PER_BIT = clks_per_bit(SPEED_MHZ, BAUD);
    localparam int PKT_BYTES    = (ICARUS != 0) ? ICARUS_PKT_BYTES : KRAMBLE_PKT_BYTES;
    localparam int PKT_BITS     = PKT_BYTES * 8;
    localparam logic [6:0] LAST_INDEX = 7'(PKT_BYTES - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("work_transmit: CLKS_PER_BIT must be at least 2");
    end

    tx_state_t           phase_r;
    logic [PKT_BITS-1:0] shift_r;
    logic [6:0]          index_r;
    logic                busy_r;
    logic                done_r;

    logic [PKT_BITS-1:0] image_s;
    logic                accept_s;
    logic                last_byte_s;
    logic                stop_exit_s;
    logic                load_s;
    logic [7:0]          next_byte_s;
    logic                gap_s;
    logic                line_busy_s;
    logic                line_txd_s;

    if (ICARUS != 0) begin : g_icarus
        assign image_s = {midstate, {ICARUS_PAD_BITS{1'b0}}, data2};
    end else begin : g_kramble
        assign image_s = {midstate, data2};
    end

    // Accept/sequencing decode: first byte comes from the live image, later
    // bytes from the captured shift register as each stop bit ends.
    always_comb begin
        accept_s    = start && !busy_r;
        last_byte_s = (index_r == LAST_INDEX);
        stop_exit_s = (phase_r == ST_DATA) && !line_busy_s;
        gap_s       = !last_byte_s;
        if (accept_s) begin
            load_s      = 1'b1;
            next_byte_s = image_s[PKT_BITS-1 -: 8];
        end else if (stop_exit_s && !last_byte_s) begin
            load_s      = 1'b1;
            next_byte_s = shift_r[PKT_BITS-9 -: 8];
        end else begin
            load_s      = 1'b0;
            next_byte_s = shift_r[PKT_BITS-9 -: 8];
        end
    end

    // Packet sequencer: capture, byte advance, busy and done pulse.
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            phase_r <= ST_IDLE;
            shift_r <= '0;
            index_r <= 7'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (phase_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (accept_s) begin
                        shift_r <= image_s;
                        index_r <= 7'd0;
                        busy_r  <= 1'b1;
                        phase_r <= ST_DATA;
                    end else begin
                        busy_r  <= 1'b0;
                        phase_r <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (stop_exit_s) begin
                        if (last_byte_s) begin
                            shift_r <= '0;
                            index_r <= 7'd0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            phase_r <= ST_DONE;
                        end else begin
                            shift_r <= {shift_r[PKT_BITS-9:0], 8'h00};
                            index_r <= index_r + 7'd1;
                            done_r  <= 1'b0;
                        end
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    phase_r <= ST_IDLE;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .GAP_BITS     (GAP_BITS)
    ) u_line (
        .clk      (clk),
        .reset_in (reset_in),
        .load     (load_s),
        .byte_in  (next_byte_s),
        .gap      (gap_s),
        .TxD      (line_txd_s),
        .busy     (line_busy_s)
    );

    assign TxD        = line_txd_s;
    assign busy       = busy_r;
    assign done       = done_r;
    assign byte_index = index_r;

endmodule

// File: tb/tb_work_transmit.sv
// Bench for work_transmit: three instances (kramble, icarus, kramble with
// 2-bit gaps) at 4 clocks per bit, UART line decoders and a byte-level model.
module tb_work_transmit;

    localparam int CPB = 4;
    localparam int DEPTH = 1024;
    localparam logic [255:0] FIX_M = 256'h85a24391_2f4a7c1e_6d93b0a5_c4e1f872_19ab3cd4_5e6f7081_92a3b4c5_8b3f07ef;
    localparam logic [95:0]  FIX_D = 96'hc513051a02a99050bfec0373;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]   rst_n;
    logic [2:0]   start;
    logic [255:0] ms [3];
    logic [95:0]  d2 [3];
    wire  [2:0]   txd;
    wire  [2:0]   busy;
    wire  [2:0]   done;
    wire  [6:0]   bidx [3];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic       mon_act [3] = '{1'b0, 1'b0, 1'b0};
    int         mon_cnt [3] = '{0, 0, 0};
    logic [7:0] mon_sh  [3];
    int         rx_cnt  [3] = '{0, 0, 0};
    logic [7:0] rx_bytes  [3][DEPTH];
    int         start_cyc [3][DEPTH];

    work_transmit #(.SPEED_MHZ(1), .BAUD(250000), .ICARUS(0), .GAP_BITS(0)) dut_k (
        .clk(clk), .reset_in(rst_n[0]), .start(start[0]), .midstate(ms[0]), .data2(d2[0]),
        .TxD(txd[0]), .busy(busy[0]), .done(done[0]), .byte_index(bidx[0]));
    work_transmit #(.SPEED_MHZ(1), .BAUD(250000), .ICARUS(1), .GAP_BITS(0)) dut_i (
        .clk(clk), .reset_in(rst_n[1]), .start(start[1]), .midstate(ms[1]), .data2(d2[1]),
        .TxD(txd[1]), .busy(busy[1]), .done(done[1]), .byte_index(bidx[1]));
    work_transmit #(.SPEED_MHZ(1), .BAUD(250000), .ICARUS(0), .GAP_BITS(2)) dut_g (
        .clk(clk), .reset_in(rst_n[2]), .start(start[2]), .midstate(ms[2]), .data2(d2[2]),
        .TxD(txd[2]), .busy(busy[2]), .done(done[2]), .byte_index(bidx[2]));

    // Count rising edges; read only on falling edges.
    always @(posedge clk) cyc <= cyc + 1;

    // UART decoders: sample mid-bit, record each byte and its start-bit cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!mon_act[k]) begin
                if (txd[k] == 1'b0) begin
                    mon_act[k] <= 1'b1;
                    mon_cnt[k] <= 1;
                    start_cyc[k][rx_cnt[k] % DEPTH] <= cyc;
                end
            end else begin
                mon_cnt[k] <= mon_cnt[k] + 1;
                if (mon_cnt[k] >= CPB + CPB / 2 && mon_cnt[k] < 9 * CPB && ((mon_cnt[k] - CPB / 2) % CPB) == 0) begin
                    mon_sh[k] <= {txd[k], mon_sh[k][7:1]};
                end else if (mon_cnt[k] == 9 * CPB + CPB / 2) begin
                    rx_bytes[k][rx_cnt[k] % DEPTH] <= mon_sh[k];
                    rx_cnt[k] <= rx_cnt[k] + 1;
                    mon_act[k] <= 1'b0;
                end
            end
        end
    end

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int pkt_bytes(input int k);
        return (k == 1) ? 64 : 44;
    endfunction

    function automatic int gap_bits(input int k);
        return (k == 2) ? 2 : 0;
    endfunction

    function automatic int exp_latency(input int k);
        return pkt_bytes(k) * 10 * CPB + (pkt_bytes(k) - 1) * gap_bits(k) * CPB;
    endfunction

    // Reference packet: midstate bytes, optional zero pad, data2 bytes, MSB first.
    function automatic logic [7:0] ref_byte(input int j, input logic [255:0] m, input logic [95:0] d, input bit ica);
        int tail;
        tail = ica ? 52 : 32;
        if (j < 32) return m[255 - 8 * j -: 8];
        else if (j < tail) return 8'h00;
        else return d[95 - 8 * (j - tail) -: 8];
    endfunction

    function automatic logic [255:0] rand_m();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32 * i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [95:0] rand_d();
        logic [95:0] v;
        for (int i = 0; i < 3; i++) v[32 * i +: 32] = $urandom;
        return v;
    endfunction

    task automatic launch(input int k, input logic [255:0] m, input logic [95:0] d, output int acc, output int rb);
        rb = rx_cnt[k];
        ms[k] = m;
        d2[k] = d;
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        acc = cyc;
        check_value($sformatf("accept_busy%0d", k), 64'(busy[k]), 64'd1);
        check_value($sformatf("accept_txd%0d", k), 64'(txd[k]), 64'd0);
    endtask

    task automatic wait_done(input int k, output int dcyc, output int blow);
        int n;
        n = 0;
        blow = 0;
        while (n < 4000) begin
            @(negedge clk);
            n++;
            if (done[k]) break;
            if (!busy[k]) blow++;
        end
        dcyc = cyc;
        check_value($sformatf("done_pulse%0d", k), 64'(done[k]), 64'd1);
        check_value($sformatf("done_busy%0d", k), 64'(busy[k]), 64'd0);
        check_value($sformatf("busy_held%0d", k), 64'(blow), 64'd0);
    endtask

    task automatic check_bytes(input int k, input int rb, input logic [255:0] m, input logic [95:0] d, input int first);
        check_value($sformatf("first_start%0d", k), 64'(start_cyc[k][rb % DEPTH]), 64'(first));
        for (int j = 0; j < pkt_bytes(k); j++) begin
            check_value($sformatf("dut%0d_byte%0d", k, j), 64'(rx_bytes[k][(rb + j) % DEPTH]), 64'(ref_byte(j, m, d, k == 1)));
            if (j > 0)
                check_value($sformatf("dut%0d_spacing%0d", k, j),
                            64'(start_cyc[k][(rb + j) % DEPTH] - start_cyc[k][(rb + j - 1) % DEPTH]),
                            64'(10 * CPB + gap_bits(k) * CPB));
        end
    endtask

    task automatic run_full(input int k, input logic [255:0] m, input logic [95:0] d);
        int acc, rb, dc, blow;
        launch(k, m, d, acc, rb);
        wait_done(k, dc, blow);
        check_value($sformatf("latency%0d", k), 64'(dc - acc), 64'(exp_latency(k)));
        repeat (2) @(negedge clk);
        check_value($sformatf("nbytes%0d", k), 64'(rx_cnt[k] - rb), 64'(pkt_bytes(k)));
        check_bytes(k, rb, m, d, acc);
    endtask

    initial begin
        int acc, acc2, rb, dc, dc2, blow, n, cnt_done, cnt_busy;
        logic [255:0] ma;
        logic [95:0]  da;
        rst_n = 3'b000;
        start = 3'b000;
        for (int k = 0; k < 3; k++) begin
            ms[k] = 256'h0;
            d2[k] = 96'h0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_value($sformatf("rst_txd%0d", k), 64'(txd[k]), 64'd1);
            check_value($sformatf("rst_busy%0d", k), 64'(busy[k]), 64'd0);
            check_value($sformatf("rst_done%0d", k), 64'(done[k]), 64'd0);
            check_value($sformatf("rst_bidx%0d", k), 64'(bidx[k]), 64'd0);
        end
        rst_n = 3'b111;
        @(negedge clk);

        // Fixed work unit on all three formats, then random ones.
        for (int k = 0; k < 3; k++) run_full(k, FIX_M, FIX_D);
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 3; k++) run_full(k, rand_m(), rand_d());

        // Start while busy is ignored; input changes mid-packet do not matter.
        ma = rand_m();
        da = rand_d();
        launch(0, ma, da, acc, rb);
        n = 0;
        while (bidx[0] != 7'd10 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_value("bidx10_time", 64'(cyc - acc), 64'(10 * 10 * CPB));
        start[0] = 1'b1;
        ms[0] = ~ma;
        d2[0] = ~da;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, dc, blow);
        check_value("ignored_latency", 64'(dc - acc), 64'(exp_latency(0)));
        cnt_done = 0;
        cnt_busy = 0;
        repeat (100) begin
            @(negedge clk);
            if (done[0]) cnt_done++;
            if (busy[0]) cnt_busy++;
        end
        check_value("ignored_no_done", 64'(cnt_done), 64'd0);
        check_value("ignored_no_busy", 64'(cnt_busy), 64'd0);
        check_value("ignored_nbytes", 64'(rx_cnt[0] - rb), 64'd44);
        check_bytes(0, rb, ma, da, acc);

        // Back-to-back: start held across done, new data2 = 0.
        ma = rand_m();
        da = rand_d();
        rb = rx_cnt[0];
        ms[0] = ma;
        d2[0] = da;
        start[0] = 1'b1;
        @(negedge clk);
        acc = cyc;
        wait_done(0, dc, blow);
        check_value("b2b_lat1", 64'(dc - acc), 64'(exp_latency(0)));
        check_value("b2b_idle_txd", 64'(txd[0]), 64'd1);
        d2[0] = 96'h0;
        @(negedge clk);
        start[0] = 1'b0;
        acc2 = cyc;
        check_value("b2b_gap", 64'(acc2 - dc), 64'd1);
        check_value("b2b_busy", 64'(busy[0]), 64'd1);
        check_value("b2b_txd", 64'(txd[0]), 64'd0);
        wait_done(0, dc2, blow);
        check_value("b2b_lat2", 64'(dc2 - acc2), 64'(exp_latency(0)));
        repeat (2) @(negedge clk);
        check_value("b2b_nbytes", 64'(rx_cnt[0] - rb), 64'd88);
        check_bytes(0, rb, ma, da, acc);
        check_bytes(0, rb + 44, ma, 96'h0, acc2);

        // Reset mid-packet while byte 20 is in its data bits.
        launch(0, rand_m(), rand_d(), acc, rb);
        n = 0;
        while (bidx[0] != 7'd20 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (12) @(negedge clk);
        rst_n[0] = 1'b0;
        @(negedge clk);
        check_value("midrst_txd", 64'(txd[0]), 64'd1);
        check_value("midrst_busy", 64'(busy[0]), 64'd0);
        check_value("midrst_bidx", 64'(bidx[0]), 64'd0);
        check_value("midrst_done", 64'(done[0]), 64'd0);
        rst_n[0] = 1'b1;
        cnt_done = 0;
        cnt_busy = 0;
        repeat (60) begin
            @(negedge clk);
            if (done[0]) cnt_done++;
            if (busy[0] || !txd[0]) cnt_busy++;
        end
        check_value("midrst_no_done", 64'(cnt_done), 64'd0);
        check_value("midrst_idle", 64'(cnt_busy), 64'd0);
        run_full(0, rand_m(), rand_d());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/work_transmit.md
Name: work_transmit

Overview:
- Host-end serial transmitter for the miner's work protocol: the sending side of what the miner's serial receiver expects.
- Latches one work unit (midstate plus the 96-bit data tail) and sends it as a fixed-length 8N1 UART packet: 44 bytes in kramble format, or 64 bytes in icarus format.
- Used as the stimulus source in hardware-in-loop rigs and in full-chain simulation, driving the miner's RxD.

Parameters:
- SPEED_MHZ, 50, clk frequency in MHz.
- BAUD, 115200, line rate. CLKS_PER_BIT = SPEED_MHZ*1000000/BAUD (integer division); values below 2 are a compile-time error.
- ICARUS, 0, 0 = 44-byte kramble packet; 1 = 64-byte icarus packet.
- GAP_BITS, 0, idle-high bit periods inserted after each stop bit, except after the last byte.

Ports:
- clk  input  1  single clock
- reset_in  input  1  synchronous, active-low reset
- start  input  1  request to send; sampled only when busy=0
- midstate  input  256  work midstate, captured on accepted start
- data2  input  96  data tail (merkle/time/bits), captured on accepted start
- TxD  output  1  UART line, idle high
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when the packet completes
- byte_index  output  7  index of the byte currently on the line (debug/verification)

Behaviour:
- Reset (reset_in=0 at a clk edge):
  - Next cycle: TxD=1, busy=0, done=0, byte_index=0, FSM=IDLE, shift register cleared.
  - Reset mid-packet aborts immediately. The truncated byte is not completed; TxD returns high.
- Packet image, captured on accept into a shift register (352 or 512 bits):
  - kramble: {midstate, data2}.
  - icarus: {midstate, 160'h0, data2}.
  - Bytes are sent most-significant byte first: first byte = midstate[255:248], last byte = data2[7:0].
  - Bits within each byte are sent LSB first.
- Accept: start=1 while busy=0 at edge N. At N+1, busy=1 and TxD=0 (start bit begins).
- start while busy=1 is ignored. It is not queued.
- FSM states:
  - IDLE: start accepted -> START.
  - START: TxD=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: 8 bits of CLKS_PER_BIT each, LSB first -> STOP.
  - STOP: TxD=1 for CLKS_PER_BIT cycles. Then:
    - last byte -> DONE;
    - else if GAP_BITS>0 -> GAP;
    - else -> START.
  - GAP: TxD=1 for GAP_BITS*CLKS_PER_BIT cycles -> START.
  - DONE: done=1 and busy=0 for exactly one cycle -> IDLE.
- Counters:
  - Bit-period counter counts 0..CLKS_PER_BIT-1.
  - Bit counter is 3 bits.
  - byte_index is 0..PKT_BYTES-1 and increments on each STOP exit.
  - The shift register shifts left by 8 on each STOP exit.
- Latency, GAP_BITS=0: done asserts at cycle N+1+PKT_BYTES*10*CLKS_PER_BIT. Packet line time is exactly PKT_BYTES*10*CLKS_PER_BIT.
- Back-to-back: start held high in the done cycle is accepted, because busy=0 in that cycle. The next start bit begins the following cycle, so the line shows a minimum 1-cycle idle gap between packets.
- Input stability: midstate and data2 are don't-care after the accept cycle. Changes mid-packet must not affect the line.
- TxD is driven from a register (no combinational glitches).

Decomposition:
- Shared package/include file holds:
  - KRAMBLE_PKT_BYTES=44 and ICARUS_PKT_BYTES=64;
  - ICARUS_PAD_BITS=160;
  - FSM state encodings (IDLE, START, DATA, STOP, GAP, DONE);
  - a CLKS_PER_BIT function shared with the receiver and transmitter.
- One natural sub-module, uart_tx_byte:
  - handles START/DATA/STOP/GAP timing for a single byte;
  - ports: clk, reset_in, load, byte_in[7:0], gap, TxD, busy.
- work_transmit keeps the packet shift register, byte counter, accept/done logic and byte sequencing.

Test Plan:
- Basic kramble packet. Setup: SPEED_MHZ=1, BAUD=250000 (CLKS_PER_BIT=4). Stimulus: start with midstate=256'h85a24391...8b3f07ef, data2=96'hc513051a02a99050bfec0373. Required:
  - a UART monitor decodes 44 bytes: 85,a2,43,...,ef,c5,13,...,73;
  - done exactly 1761 cycles after the accept edge;
  - busy high throughout.
- Icarus packet (ICARUS=1), same data: 64 bytes decoded; bytes 32..51 are 00; bytes 52..63 are c5..73; done at accept+2561.
- Ignored start: pulse start again at byte_index=10 with different midstate. Required: line content unchanged; no second packet; single done.
- Back-to-back: hold start high across done with new data2=96'h0. Required: second packet starts 1 idle cycle after done; 88 bytes total; two done pulses.
- Reset mid-packet: reset_in=0 for one cycle at byte_index=20, mid DATA. Required: next cycle TxD=1, busy=0, byte_index=0, no done; a following start sends a full correct packet.
- Gap timing: GAP_BITS=2. Required: 8 idle-high clocks between each stop bit and the next start bit; none after byte 43; done at accept+1761+43*8.
